bu_unified: RTL

//  Parametrised successor butterfly for the ML-KEM NTT core: one pipelined unit that does both

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/bu_unified_if.sv | 26 ++
 rtl/bu_unified_mod_mul_barrett.sv | 59 +++++
 rtl/bu_unified.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and helpers for the ML-KEM NTT butterfly.
//   NTT_WIDTH / NTT_Q : default coefficient width and modulus
//   mode_e            : per-sample butterfly selector (CT forward / GS inverse)
//   bu_lat()          : end-to-end butterfly latency from the multiplier depths
//   barrett_m()       : Barrett constant m = floor(2^k / q), k = 2*width
package ntt_pkg;

    localparam int NTT_WIDTH = 16;
    localparam int NTT_Q     = 3329;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } mode_e;

    // Input reg + GS add/sub reg + multiplier + output reg.
    function automatic int bu_lat(input int mul_stages, input int red_stages);
        return mul_stages + red_stages + 3;
    endfunction

    function automatic longint unsigned barrett_m(input int q, input int width);
        return (64'd1 << (2 * width)) / 64'(q);
    endfunction

endpackage

// File: rtl/bu_unified_if.sv
// bu_unified_if: sample-in / result-out bundle of the unified butterfly.
//   stall, in_valid, mode, A_In, B_In, W_In : driven by the controller (master)
//   out_valid, A_Out, B_Out                 : driven by the butterfly (slave)
interface bu_unified_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             in_valid;
    logic             mode;
    logic [WIDTH-1:0] A_In;
    logic [WIDTH-1:0] B_In;
    logic [WIDTH-1:0] W_In;
    logic             out_valid;
    logic [WIDTH-1:0] A_Out;
    logic [WIDTH-1:0] B_Out;

    modport master (
        output stall, in_valid, mode, A_In, B_In, W_In,
        input  out_valid, A_Out, B_Out
    );

    modport slave (
        input  stall, in_valid, mode, A_In, B_In, W_In,
        output out_valid, A_Out, B_Out
    );
endinterface

// File: rtl/bu_unified_mod_mul_barrett.sv
// mod_mul_barrett: pipelined (a*b) mod Q, latency MUL_STAGES + RED_STAGES.
//   clk, rst : clock, async active-high reset
//   stall    : 1 = hold every internal register
//   a, b     : operands in [0,Q)
//   p        : product mod Q, fully reduced
module mod_mul_barrett
    import ntt_pkg::*;
#(
    parameter int WIDTH      = NTT_WIDTH,
    parameter int Q          = NTT_Q,
    parameter int MUL_STAGES = 1,
    parameter int RED_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);
    localparam int             K  = 2 * WIDTH;
    localparam logic [K-1:0]   QK = K'(Q);
    localparam logic [2*K-1:0] M  = (2*K)'(barrett_m(Q, WIDTH));

    logic [MUL_STAGES-1:0][K-1:0] mul_q, mul_d;
    // Reducer carries the product and its quotient estimate side by side.
    logic [RED_STAGES-1:0][K-1:0] rx_q, rx_d, rt_q, rt_d;
    logic [2*K-1:0]               xm;
    logic [K-1:0]                 r;

    always_comb begin
        mul_d[0] = K'(a) * K'(b);
        for (int i = 1; i < MUL_STAGES; i++) mul_d[i] = mul_q[i-1];

        xm       = (2*K)'(mul_q[MUL_STAGES-1]) * M;
        rx_d[0]  = mul_q[MUL_STAGES-1];
        rt_d[0]  = K'(xm >> K);
        for (int i = 1; i < RED_STAGES; i++) begin
            rx_d[i] = rx_q[i-1];
            rt_d[i] = rt_q[i-1];
        end

        // Quotient estimate is low by at most one, so r < 2Q.
        r = rx_q[RED_STAGES-1] - rt_q[RED_STAGES-1] * QK;
        p = (r >= QK) ? WIDTH'(r - QK) : WIDTH'(r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_q <= '0;
            rx_q  <= '0;
            rt_q  <= '0;
        end else if (!stall) begin
            mul_q <= mul_d;
            rx_q  <= rx_d;
            rt_q  <= rt_d;
        end
    end
endmodule

// File: rtl/bu_unified.sv
// bu_unified: pipelined CT/GS butterfly mod Q, mode selectable per sample.
//   clk, rst : clock, async active-high reset (flushes all in-flight samples)
//   bus      : bu_unified_if.slave (stall, in_valid, mode, A/B/W_In -> out_valid, A/B_Out)
// Latency is MUL_STAGES + RED_STAGES + 3 in both modes.
// Build option HALF_EN: GS results are multiplied by 2^-1 mod Q in the output stage.
module bu_unified
    import ntt_pkg::*;
#(
    parameter int WIDTH      = NTT_WIDTH,
    parameter int Q          = NTT_Q,
    parameter int MUL_STAGES = 1,
    parameter int RED_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    bu_unified_if.slave   bus
);
    localparam int             MR  = MUL_STAGES + RED_STAGES;
    localparam int             LAT = bu_lat(MUL_STAGES, RED_STAGES);
    localparam logic [WIDTH:0] QE  = (WIDTH+1)'(Q);

    function automatic logic [WIDTH-1:0] add_q(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QE) s = s - QE;
        return s[WIDTH-1:0];
    endfunction

    // x - y mod Q; a set top bit of the WIDTH+1 difference means it went negative.
    function automatic logic [WIDTH-1:0] sub_q(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[WIDTH]) d = d + QE;
        return d[WIDTH-1:0];
    endfunction

`ifdef HALF_EN
    // x * 2^-1 mod Q: odd values become even by adding Q (Q is odd).
    function automatic logic [WIDTH-1:0] half_q(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] e;
        e = x[0] ? ({1'b0, x} + QE) : {1'b0, x};
        return e[WIDTH:1];
    endfunction
`endif

    logic [LAT-1:0]             vld_q, vld_d;
    logic [WIDTH-1:0]           a0_q, a0_d, b0_q, b0_d, w0_q, w0_d;
    logic                       mode0_q, mode0_d;
    logic [WIDTH-1:0]           x1_q, x1_d, y1_q, y1_d, w1_q, w1_d;
    logic                       mode1_q, mode1_d;
    logic [MR-1:0][WIDTH-1:0]   x_dly_q, x_dly_d;
    logic [MR-1:0]              mode_dly_q, mode_dly_d;
    logic [WIDTH-1:0]           a_out_q, a_out_d, b_out_q, b_out_d;
    logic [WIDTH-1:0]           prod;
    logic [WIDTH-1:0]           xd;

    // Operands: (w, b) for CT, (w, b-a) for GS.
    mod_mul_barrett #(
        .WIDTH(WIDTH), .Q(Q), .MUL_STAGES(MUL_STAGES), .RED_STAGES(RED_STAGES)
    ) u_mul (
        .clk(clk), .rst(rst), .stall(bus.stall),
        .a(w1_q), .b(y1_q), .p(prod)
    );

    always_comb begin
        vld_d[0] = bus.in_valid;
        for (int i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];

        // Invalid slots load zeros so an undriven bus never seeds X into the pipe.
        a0_d    = bus.in_valid ? bus.A_In : '0;
        b0_d    = bus.in_valid ? bus.B_In : '0;
        w0_d    = bus.in_valid ? bus.W_In : '0;
        mode0_d = bus.in_valid ? bus.mode : MODE_CT;

        // GS add/sub; CT passes a and b straight through.
        if (mode0_q == MODE_GS) begin
            x1_d = add_q(a0_q, b0_q);
            y1_d = sub_q(b0_q, a0_q);
        end else begin
            x1_d = a0_q;
            y1_d = b0_q;
        end
        w1_d    = w0_q;
        mode1_d = mode0_q;

        // a (CT) or a+b (GS) rides alongside the multiplier.
        x_dly_d[0]    = x1_q;
        mode_dly_d[0] = mode1_q;
        for (int i = 1; i < MR; i++) begin
            x_dly_d[i]    = x_dly_q[i-1];
            mode_dly_d[i] = mode_dly_q[i-1];
        end

        xd = x_dly_q[MR-1];
        if (mode_dly_q[MR-1] == MODE_CT) begin
            a_out_d = add_q(xd, prod);
            b_out_d = sub_q(xd, prod);
        end else begin
`ifdef HALF_EN
            a_out_d = half_q(xd);
            b_out_d = half_q(prod);
`else
            a_out_d = xd;
            b_out_d = prod;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            a0_q       <= '0;
            b0_q       <= '0;
            w0_q       <= '0;
            mode0_q    <= 1'b0;
            x1_q       <= '0;
            y1_q       <= '0;
            w1_q       <= '0;
            mode1_q    <= 1'b0;
            x_dly_q    <= '0;
            mode_dly_q <= '0;
            a_out_q    <= '0;
            b_out_q    <= '0;
        end else if (!bus.stall) begin
            vld_q      <= vld_d;
            a0_q       <= a0_d;
            b0_q       <= b0_d;
            w0_q       <= w0_d;
            mode0_q    <= mode0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            w1_q       <= w1_d;
            mode1_q    <= mode1_d;
            x_dly_q    <= x_dly_d;
            mode_dly_q <= mode_dly_d;
            a_out_q    <= a_out_d;
            b_out_q    <= b_out_d;
        end
    end

    assign bus.out_valid = vld_q[LAT-1];
    assign bus.A_Out     = a_out_q;
    assign bus.B_Out     = b_out_q;
endmodule
